exec_sequencer: RTL

//  Multi-cycle issue/writeback sequencer between the instruction source and the ALU/register file.

---
 rtl/exec_sequencer_if.sv | 31 +++
 rtl/exec_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// Instruction handshake and ALU/register-file control bundle for exec_sequencer.
interface exec_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             inst_valid;
    logic [15:0]      inst;
    logic             inst_ready;
    logic             alu_start;
    logic [2:0]       aluop;
    logic             alusrc;
    logic             rf_wen;
    logic [3:0]       rf_waddr;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] illegal_cnt;

    // Instruction source and observer of the sequencer outputs
    modport master (
        output inst_valid, inst,
        input  inst_ready, alu_start, aluop, alusrc, rf_wen, rf_waddr,
               illegal, busy, retired, illegal_cnt
    );

    // Sequencer side
    modport slave (
        input  inst_valid, inst,
        output inst_ready, alu_start, aluop, alusrc, rf_wen, rf_waddr,
               illegal, busy, retired, illegal_cnt
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle issue/writeback sequencer: accepts 16-bit instructions, drives the
// ALU controls, stalls for MUL latency, strobes the register-file write and
// counts retired and illegal instructions.
`ifndef ADD
`define ADD 4'b0000
`define SUB 4'b0001
`define AND 4'b0010
`define OR  4'b0011
`define XOR 4'b0100
`define SLL 4'b0101
`define SRL 4'b0110
`define MUL 4'b0111
`endif

module exec_sequencer #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    exec_sequencer_if.slave   bus
);
    localparam int unsigned LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULW = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             inst_ready_q;
    logic             alu_start_q;
    logic [2:0]       aluop_q;
    logic             alusrc_q;
    logic             rf_wen_q;
    logic [3:0]       rf_waddr_q;
    logic             illegal_q;
    logic             busy_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    logic [3:0]       opcode;
    logic             xfer;

    assign opcode = bus.inst[15:12];
    assign xfer   = bus.inst_valid & inst_ready_q;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            inst_ready_q  <= 1'b1;
            alu_start_q   <= 1'b0;
            aluop_q       <= 3'd0;
            alusrc_q      <= 1'b0;
            rf_wen_q      <= 1'b0;
            rf_waddr_q    <= 4'd0;
            illegal_q     <= 1'b0;
            busy_q        <= 1'b0;
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            alu_start_q <= 1'b0;
            rf_wen_q    <= 1'b0;
            illegal_q   <= 1'b0;
            case (state)
                IDLE, WB: begin
                    if (xfer && opcode[3]) begin
                        // Illegal opcode: consumed, controls left untouched
                        illegal_q     <= 1'b1;
                        illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
                        state         <= IDLE;
                        inst_ready_q  <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (xfer) begin
                        aluop_q      <= opcode[2:0];
                        alusrc_q     <= (opcode == `SLL) || (opcode == `SRL);
                        rf_waddr_q   <= bus.inst[11:8];
                        alu_start_q  <= 1'b1;
                        inst_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        if (opcode == `MUL) begin
                            state <= MULW;
                            cnt   <= LAT_W'(MUL_LAT - 1);
                        end else begin
                            state <= EXEC;
                        end
                    end else begin
                        state        <= IDLE;
                        inst_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                EXEC: begin
                    state        <= WB;
                    rf_wen_q     <= 1'b1;
                    retired_q    <= retired_q + CNT_W'(1);
                    inst_ready_q <= 1'b1;
                    busy_q       <= 1'b1;
                end
                MULW: begin
                    if (cnt == '0) begin
                        state        <= WB;
                        rf_wen_q     <= 1'b1;
                        retired_q    <= retired_q + CNT_W'(1);
                        inst_ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                    busy_q <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    inst_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_ready  = inst_ready_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.aluop       = aluop_q;
    assign bus.alusrc      = alusrc_q;
    assign bus.rf_wen      = rf_wen_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.illegal     = illegal_q;
    assign bus.busy        = busy_q;
    assign bus.retired     = retired_q;
    assign bus.illegal_cnt = illegal_cnt_q;
endmodule
